// File: rtl/write_fifo_pkg.sv
// write_fifo_pkg: shared pointer-width helpers and Gray/binary conversion for the CDC FIFO.
package write_fifo_pkg;
    // Conversions run on a 32-bit carrier. Zero-extended narrower pointers convert correctly
    // and are truncated back by the caller, so one pair of functions serves every width.
    localparam int MAX_W = 32;
    localparam int ADDR_WIDTH_DEF = 3;

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction

    function automatic int ptr_width(input int aw);
        return aw + 1;
    endfunction

    localparam int DEPTH_DEF = depth(ADDR_WIDTH_DEF);
    localparam int PTR_WIDTH_DEF = ptr_width(ADDR_WIDTH_DEF);

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/write_fifo_gray_top_if.sv
// write_fifo_gray_top_if: write-client, memory and read-pointer signals of the FIFO write side.
interface write_fifo_gray_top_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  w_request_in;
    logic                  w_overflow_clr_in;
    logic [ADDR_WIDTH:0]   r_ptr_gray_in;
    logic                  w_en_out;
    logic [ADDR_WIDTH-1:0] w_addr_out;
    logic [ADDR_WIDTH:0]   w_ptr_gray_out;
    logic                  w_full_out;
    logic                  w_almost_full_out;
    logic [ADDR_WIDTH:0]   w_count_out;
    logic                  w_overflow_out;

    modport master (
        output w_request_in, w_overflow_clr_in, r_ptr_gray_in,
        input  w_en_out, w_addr_out, w_ptr_gray_out, w_full_out,
               w_almost_full_out, w_count_out, w_overflow_out
    );

    modport slave (
        input  w_request_in, w_overflow_clr_in, r_ptr_gray_in,
        output w_en_out, w_addr_out, w_ptr_gray_out, w_full_out,
               w_almost_full_out, w_count_out, w_overflow_out
    );
endinterface

// File: rtl/sync_ptr_gray.sv
// sync_ptr_gray: multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
module sync_ptr_gray #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] ptr_gray_in,
    output logic [WIDTH-1:0] ptr_gray_out
);
    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the incoming Gray pointer through the chain; only one bit changes at a time upstream
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stage_q <= '{default: '0};
        end else begin
            stage_q[0] <= ptr_gray_in;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign ptr_gray_out = stage_q[STAGES-1];
endmodule

// File: rtl/write_fifo_gray_top.sv
// write_fifo_gray_top: write-side pointer, Gray export and full/count/overflow status of a CDC FIFO.
module write_fifo_gray_top
    import write_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = 2**ADDR_WIDTH - 1
) (
    input logic w_clk_in,
    input logic w_reset_n_in,
    write_fifo_gray_top_if.slave bus
);
    localparam int PW = ptr_width(ADDR_WIDTH);
    localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          af_q, af_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] rsync;
    logic [PW-1:0] rbin;
    logic          w_en;

    sync_ptr_gray #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rsync (
        .clk_in       (w_clk_in),
        .rst_n_in     (w_reset_n_in),
        .ptr_gray_in  (bus.r_ptr_gray_in),
        .ptr_gray_out (rsync)
    );

    // Next pointer and status; full compares Gray pointers with the top two read bits inverted
    always_comb begin
        w_en    = bus.w_request_in & ~full_q;
        rbin    = PW'(gray2bin(MAX_W'(rsync)));
        wbin_d  = wbin_q + PW'(w_en);
        wgray_d = PW'(bin2gray(MAX_W'(wbin_d)));
        full_d  = wgray_d == {~rsync[PW-1:PW-2], rsync[PW-3:0]};
        count_d = wbin_d - rbin;
        af_d    = count_d >= AF_THR;
        ovf_d   = (bus.w_request_in & full_q) | (ovf_q & ~bus.w_overflow_clr_in);
    end

    // Pointer, exported Gray pointer and status registers
    always_ff @(posedge w_clk_in or negedge w_reset_n_in) begin
        if (!w_reset_n_in) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            count_q <= count_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.w_en_out          = w_en;
    assign bus.w_addr_out        = wbin_q[ADDR_WIDTH-1:0];
    assign bus.w_ptr_gray_out    = wgray_q;
    assign bus.w_full_out        = full_q;
    assign bus.w_almost_full_out = af_q;
    assign bus.w_count_out       = count_q;
    assign bus.w_overflow_out    = ovf_q;
endmodule
